// File: rtl/mem_sa_ctrl_if.sv
// Interface between the systolic-array memory controller and its environment:
// job control, single-port BRAM port, weight/activation feed and result return.
interface mem_sa_ctrl_if #(
    parameter int unsigned ROWS      = 4,
    parameter int unsigned COLS      = 4,
    parameter int unsigned WORD_SIZE = 16
);
    localparam int unsigned PW = COLS * WORD_SIZE;
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic          start;
    logic          busy;
    logic          done;
    logic [31:0]   mem_addr;
    logic          mem_we;
    logic [PW-1:0] mem_di;
    logic [PW-1:0] mem_dout;
    logic          w_valid;
    logic [RW-1:0] w_row;
    logic [PW-1:0] w_data;
    logic          a_valid;
    logic [PW-1:0] a_data;
    logic          res_valid;
    logic [PW-1:0] res_data;
    logic          res_ready;

    // Controller side.
    modport master (
        input  start, mem_dout, res_valid, res_data,
        output busy, done, mem_addr, mem_we, mem_di,
        output w_valid, w_row, w_data, a_valid, a_data, res_ready
    );

    // Environment side (BRAM, systolic array, job issuer).
    modport slave (
        output start, mem_dout, res_valid, res_data,
        input  busy, done, mem_addr, mem_we, mem_di,
        input  w_valid, w_row, w_data, a_valid, a_data, res_ready
    );
endinterface

// File: rtl/mem_sa_ctrl.sv
// Sequencer for one systolic-array matrix job: reads ROWS weight lines, streams
// ROWS+COLS-1 staggered activation lines, then writes ROWS result lines back.
module mem_sa_ctrl #(
    parameter int unsigned ROWS      = 4,
    parameter int unsigned COLS      = 4,
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned W_BASE    = 0,
    parameter int unsigned A_BASE    = 4,
    parameter int unsigned O_BASE    = 11
) (
    input logic            clk,
    input logic            rst,
    mem_sa_ctrl_if.master  bus
);
    localparam int unsigned PW = COLS * WORD_SIZE;
    localparam int unsigned NA = ROWS + COLS - 1;
    localparam int unsigned CW = $clog2(NA + 1);
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StStream,
        StWaitRes,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          w_valid_q;
    logic [RW-1:0] w_row_q;
    logic          a_valid_q;

    logic [31:0]   mem_addr;
    logic          mem_we;
    logic [PW-1:0] mem_di;
    logic          res_ready;

    // Next state, shared step counter and the combinational BRAM port.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_di    = '0;
        res_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StLoadW;
                    cnt_d   = '0;
                end
            end
            StLoadW: begin
                mem_addr = 32'(W_BASE) + 32'(cnt_q);
                if (cnt_q == CW'(ROWS - 1)) begin
                    state_d = StStream;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStream: begin
                mem_addr = 32'(A_BASE) + 32'(cnt_q);
                if (cnt_q == CW'(NA - 1)) begin
                    state_d = StWaitRes;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitRes: begin
                res_ready = 1'b1;
                mem_addr  = 32'(O_BASE) + 32'(cnt_q);
                // A result is accepted and written in the same cycle.
                if (bus.res_valid) begin
                    mem_we = 1'b1;
                    mem_di = bus.res_data;
                    if (cnt_q == CW'(ROWS - 1)) begin
                        state_d = StDone;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // State register plus the valids that track last cycle's BRAM reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            w_valid_q <= 1'b0;
            w_row_q   <= '0;
            a_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            w_valid_q <= (state_q == StLoadW);
            w_row_q   <= (state_q == StLoadW) ? RW'(cnt_q) : '0;
            a_valid_q <= (state_q == StStream);
        end
    end

    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_we    = mem_we;
    assign bus.mem_di    = mem_di;
    assign bus.res_ready = res_ready;
    assign bus.w_valid   = w_valid_q;
    assign bus.w_row     = w_row_q;
    assign bus.w_data    = bus.mem_dout;
    assign bus.a_valid   = a_valid_q;
    assign bus.a_data    = bus.mem_dout;

endmodule

// File: tb/tb_mem_sa_ctrl.sv
// Self-checking bench for mem_sa_ctrl: directed timeline table, corner-case
// sequences and a randomized run, all checked against a job-position model.
module tb_mem_sa_ctrl;
    localparam int unsigned ROWS = 4, COLS = 4, WS = 16;
    localparam int unsigned W_BASE = 0, A_BASE = 4, O_BASE = 11;
    localparam int unsigned NA = ROWS + COLS - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_sa_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WS)) bus ();

    mem_sa_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WS),
        .W_BASE(W_BASE), .A_BASE(A_BASE), .O_BASE(O_BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // BRAM model: one-cycle read latency, write-enable port.
    logic [63:0] img [32];
    logic [63:0] mem [32];
    logic        load_img = 1'b0;
    always @(posedge clk) begin
        if (load_img) begin
            for (int i = 0; i < 32; i++) mem[i] <= img[i];
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[4:0]] <= bus.mem_di;
        end
        bus.mem_dout <= mem[bus.mem_addr[4:0]];
    end

    int checks = 0;
    int errs   = 0;
    int cyc_n  = 0;
    int done_log[$];
    int first_wr;
    bit zchk = 0;

    // Model: mt = cycles into the read phase (-1 idle), mw = results accepted.
    int          mt = -1;
    int          mw = 0;
    int          pk = 0;
    bit          pw = 0;
    bit          pa = 0;
    logic [31:0] paddr = 0;

    typedef struct {
        logic        s, rv;
        logic        busy, done, we;
        logic [31:0] addr;
        logic        wv;
        logic [1:0]  wr;
        logic        av, rdy;
        bit          wd_chk, ad_chk;
        logic [63:0] wd, ad;
    } vec_t;
    vec_t tbl [18];
    logic [63:0] res_seq [4];

    function automatic vec_t mk(logic s, logic rv, logic busy, logic done, logic we,
                                logic [31:0] addr, logic wv, logic [1:0] wr,
                                logic av, logic rdy);
        vec_t v;
        v.s = s; v.rv = rv; v.busy = busy; v.done = done; v.we = we; v.addr = addr;
        v.wv = wv; v.wr = wr; v.av = av; v.rdy = rdy;
        v.wd_chk = 0; v.ad_chk = 0; v.wd = '0; v.ad = '0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc_n, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against model (and table row ti), clock.
    task automatic cyc(input logic s, input logic rv, input logic [63:0] rd, input logic r,
                       input int ti);
        logic        e_busy, e_done, e_we, e_rdy;
        logic [31:0] e_addr;
        bit          rdw, rda, addr_chk;
        @(negedge clk);
        bus.start = s; bus.res_valid = rv; bus.res_data = rd; rst = r;
        #1;
        e_busy = 0; e_done = 0; e_we = 0; e_rdy = 0; e_addr = '0;
        rdw = 0; rda = 0; addr_chk = 0;
        if (mt >= 0) begin
            e_busy = 1;
            if (mt < int'(ROWS)) begin
                e_addr = W_BASE + mt; rdw = 1; addr_chk = 1;
            end else if (mt < int'(ROWS + NA)) begin
                e_addr = A_BASE + mt - ROWS; rda = 1; addr_chk = 1;
            end else if (mw < int'(ROWS)) begin
                e_rdy = 1; e_addr = O_BASE + mw; e_we = rv; addr_chk = 1;
            end else begin
                e_done = 1;
            end
        end
        chk("busy", 64'(bus.busy), 64'(e_busy));
        chk("done", 64'(bus.done), 64'(e_done));
        chk("mem_we", 64'(bus.mem_we), 64'(e_we));
        chk("res_ready", 64'(bus.res_ready), 64'(e_rdy));
        chk("w_valid", 64'(bus.w_valid), 64'(pw));
        chk("a_valid", 64'(bus.a_valid), 64'(pa));
        if (addr_chk) chk("mem_addr", 64'(bus.mem_addr), 64'(e_addr));
        if (e_we) chk("mem_di", bus.mem_di, rd);
        if (pw) begin
            chk("w_row", 64'(bus.w_row), 64'(pk));
            chk("w_data", bus.w_data, mem[W_BASE + pk]);
        end
        if (pa) chk("a_data", bus.a_data, mem[paddr[4:0]]);
        if (zchk) begin
            zchk = 0;
            chk("rst_busy", 64'(bus.busy), 64'd0);
            chk("rst_addr", 64'(bus.mem_addr), 64'd0);
            chk("rst_w_row", 64'(bus.w_row), 64'd0);
            chk("rst_mem_di", bus.mem_di, 64'd0);
            chk("rst_valids", {61'd0, bus.w_valid, bus.a_valid, bus.res_ready}, 64'd0);
        end
        if (ti >= 0) begin
            chk("tbl_busy", 64'(bus.busy), 64'(tbl[ti].busy));
            chk("tbl_done", 64'(bus.done), 64'(tbl[ti].done));
            chk("tbl_we", 64'(bus.mem_we), 64'(tbl[ti].we));
            chk("tbl_w_valid", 64'(bus.w_valid), 64'(tbl[ti].wv));
            chk("tbl_a_valid", 64'(bus.a_valid), 64'(tbl[ti].av));
            chk("tbl_res_ready", 64'(bus.res_ready), 64'(tbl[ti].rdy));
            if (tbl[ti].busy && !tbl[ti].done) chk("tbl_addr", 64'(bus.mem_addr), 64'(tbl[ti].addr));
            if (tbl[ti].wv) chk("tbl_w_row", 64'(bus.w_row), 64'(tbl[ti].wr));
            if (tbl[ti].wd_chk) chk("tbl_w_data", bus.w_data, tbl[ti].wd);
            if (tbl[ti].ad_chk) chk("tbl_a_data", bus.a_data, tbl[ti].ad);
        end
        if (bus.done) done_log.push_back(cyc_n);
        if (bus.mem_we && first_wr < 0) first_wr = cyc_n;
        @(posedge clk);
        cyc_n++;
        if (r) begin
            mt = -1; mw = 0; pw = 0; pa = 0; pk = 0;
        end else begin
            pw = rdw; pk = mt; pa = rda; paddr = e_addr;
            if (mt < 0) begin
                if (s) mt = 0;
            end else if (mt < int'(ROWS + NA)) begin
                mt++;
            end else if (mw < int'(ROWS)) begin
                if (rv) mw++;
            end else begin
                mt = -1; mw = 0;
            end
        end
    endtask

    task automatic check_done(input string nm, input int base, input int e0, input int e1);
        int n;
        n = (e1 < 0) ? 1 : 2;
        chk({nm, "_count"}, 64'(done_log.size()), 64'(n));
        if (done_log.size() > 0) chk({nm, "_at0"}, 64'(done_log[0] - base), 64'(e0));
        if (n == 2 && done_log.size() > 1) chk({nm, "_at1"}, 64'(done_log[1] - base), 64'(e1));
    endtask

    task automatic new_seq(output int base);
        done_log.delete();
        first_wr = -1;
        base = cyc_n;
    endtask

    initial begin
        int base;
        rst = 1'b1;
        bus.start = 0; bus.res_valid = 0; bus.res_data = '0;
        res_seq[0] = 64'h00170051002b0043;
        res_seq[1] = 64'h002600ad00650055;
        res_seq[2] = 64'h002b00e800720050;
        res_seq[3] = 64'h002500dc005e0047;
        for (int i = 0; i < 32; i++) img[i] = {$urandom, $urandom};
        img[0]  = 64'h0001000000000005;
        img[3]  = 64'h0000000700010006;
        img[4]  = 64'h0000000000000009;
        img[10] = 64'h0004000000000000;

        //            s  rv busy done we addr wv wr av rdy
        tbl[0]  = mk(1, 1, 0, 0, 0, 0,  0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 0, 0, 0,  0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 1, 0, 0, 1,  1, 0, 0, 0);
        tbl[3]  = mk(0, 1, 1, 0, 0, 2,  1, 1, 0, 0);
        tbl[4]  = mk(0, 1, 1, 0, 0, 3,  1, 2, 0, 0);
        tbl[5]  = mk(0, 1, 1, 0, 0, 4,  1, 3, 0, 0);
        tbl[6]  = mk(0, 1, 1, 0, 0, 5,  0, 0, 1, 0);
        tbl[7]  = mk(0, 1, 1, 0, 0, 6,  0, 0, 1, 0);
        tbl[8]  = mk(0, 1, 1, 0, 0, 7,  0, 0, 1, 0);
        tbl[9]  = mk(0, 1, 1, 0, 0, 8,  0, 0, 1, 0);
        tbl[10] = mk(0, 1, 1, 0, 0, 9,  0, 0, 1, 0);
        tbl[11] = mk(0, 1, 1, 0, 0, 10, 0, 0, 1, 0);
        tbl[12] = mk(0, 1, 1, 0, 1, 11, 0, 0, 1, 1);
        tbl[13] = mk(0, 1, 1, 0, 1, 12, 0, 0, 0, 1);
        tbl[14] = mk(0, 1, 1, 0, 1, 13, 0, 0, 0, 1);
        tbl[15] = mk(0, 1, 1, 0, 1, 14, 0, 0, 0, 1);
        tbl[16] = mk(0, 1, 1, 1, 0, 0,  0, 0, 0, 0);
        tbl[17] = mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 0);
        tbl[2].wd_chk  = 1; tbl[2].wd  = 64'h0001000000000005;
        tbl[5].wd_chk  = 1; tbl[5].wd  = 64'h0000000700010006;
        tbl[6].ad_chk  = 1; tbl[6].ad  = 64'h0000000000000009;
        tbl[12].ad_chk = 1; tbl[12].ad = 64'h0004000000000000;

        load_img = 1'b1;
        @(posedge clk);
        #1 load_img = 1'b0;

        // Reset with start asserted: reset wins.
        cyc(1, 1, 64'h1234, 1, -1);
        cyc(1, 1, 64'h1234, 1, -1);
        zchk = 1;

        // Nominal job timeline and writeback.
        new_seq(base);
        for (int i = 0; i < 18; i++)
            cyc(tbl[i].s, tbl[i].rv, (i >= 12 && i <= 15) ? res_seq[i - 12] : 64'hbad0bad0, 0, i);
        for (int m = 0; m < 4; m++) chk("writeback", mem[O_BASE + m], res_seq[m]);
        check_done("nominal_done", base, 16, -1);

        // Results stalled for 5 cycles in WAIT_RES.
        new_seq(base);
        for (int i = 0; i < 26; i++)
            cyc(i == 0, !(i >= 12 && i < 17), {$urandom, $urandom}, 0, -1);
        check_done("stall_done", base, 21, -1);

        // Spurious start and res_valid during the read phases.
        new_seq(base);
        for (int i = 0; i < 20; i++)
            cyc(i == 0 || i == 7, 1, {$urandom, $urandom}, 0, -1);
        chk("spurious_first_write", 64'(first_wr - base), 64'd12);
        check_done("spurious_done", base, 16, -1);

        // Reset during STREAM aborts the job; a fresh job then runs normally.
        new_seq(base);
        for (int i = 0; i < 9; i++) cyc(i == 0, 1, {$urandom, $urandom}, i == 8, -1);
        zchk = 1;
        chk("abort_no_write", 64'(first_wr), 64'hffff_ffff_ffff_ffff);
        new_seq(base);
        for (int i = 0; i < 18; i++) cyc(i == 0, 1, {$urandom, $urandom}, 0, -1);
        check_done("after_abort_done", base, 16, -1);

        // Back-to-back jobs with start held high.
        new_seq(base);
        for (int i = 0; i < 36; i++) cyc(i < 34, 1, {$urandom, $urandom}, 0, -1);
        check_done("b2b_done", base, 16, 33);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, {$urandom, $urandom},
                $urandom_range(0, 99) == 0, -1);
        for (int i = 0; i < 30; i++) cyc(0, 1, {$urandom, $urandom}, 0, -1);
        chk("random_end_idle", 64'(bus.busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/mem_sa_ctrl.md
MEM_SA_CTRL -- requirements
Module: mem_sa_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ROWS, 4, SA rows / weight lines; COLS, 4, SA columns; WORD_SIZE, 16, bits per element; W_BASE, 0, first weight line; A_BASE, 4, first staggered-activation line; O_BASE, 11, first output line.
REQ-002 PW denotes COLS*WORD_SIZE (64 by default); NA denotes ROWS+COLS-1 (7 by default).
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  request one matrix job; sampled only in IDLE.
REQ-006 busy  out  1  high whenever the state is not IDLE.
REQ-007 done  out  1  one-cycle pulse when a job completes.
REQ-008 mem_addr  out  32  single-port BRAM line address.
REQ-009 mem_we  out  1  BRAM write enable.
REQ-010 mem_di  out  PW  BRAM write data.
REQ-011 mem_dout  in  PW  BRAM read data, valid one cycle after the address is issued.
REQ-012 w_valid  out  1  weight line present on w_data.
REQ-013 w_row  out  $clog2(ROWS)  row index of the presented weight line.
REQ-014 w_data  out  PW  weight line, driven from mem_dout.
REQ-015 a_valid  out  1  activation vector present on a_data.
REQ-016 a_data  out  PW  staggered activation vector, driven from mem_dout.
REQ-017 res_valid  in  1  SA result line available; held until accepted.
REQ-018 res_data  in  PW  SA result line.
REQ-019 res_ready  out  1  controller accepts a result line this cycle.

Function
REQ-020 The FSM SHALL have the states IDLE, LOAD_W, STREAM, WAIT_RES and DONE.
REQ-021 Transitions: IDLE->LOAD_W on start; LOAD_W->STREAM after ROWS reads; STREAM->WAIT_RES after NA reads; WAIT_RES->DONE after ROWS accepted writes; DONE->IDLE unconditionally.
REQ-022 LOAD_W: each cycle, mem_addr = W_BASE+k for k = 0..ROWS-1, with mem_we = 0.
REQ-023 STREAM: each cycle, mem_addr = A_BASE+j for j = 0..NA-1, with mem_we = 0.
REQ-024 mem_addr, mem_we and mem_di SHALL be combinational from the state, the counters and res_valid; a read issued in cycle c returns its data in cycle c+1.
REQ-025 w_valid and w_row SHALL be registered copies of "LOAD_W read issued" and its k, so they are high in the cycle after each LOAD_W read, including the first STREAM cycle.
REQ-026 a_valid SHALL be the registered copy of "STREAM read issued", so it is high in the cycle after each STREAM read, including the first WAIT_RES cycle.
REQ-027 w_data and a_data SHALL equal mem_dout; their values are meaningful only while the matching valid is high.
REQ-028 res_ready SHALL be high only in WAIT_RES.
REQ-029 A handshake (res_valid & res_ready) SHALL occur in the same cycle as mem_we = 1, mem_addr = O_BASE+m and mem_di = res_data; m then increments.
REQ-030 In WAIT_RES with res_valid = 0: mem_we = 0, mem_addr = O_BASE+m, and no state change; there is no timeout.
REQ-031 res_valid SHALL be ignored outside WAIT_RES, and no write SHALL occur there.
REQ-032 start SHALL be ignored while busy; start asserted in the DONE cycle is also ignored.
REQ-033 Back-to-back jobs are allowed: start sampled in IDLE the cycle after DONE begins a new job.
REQ-034 Counters SHALL clear on entry to each state; address arithmetic is unsigned 32-bit and never wraps within a job.
REQ-035 Timing with res_valid held high and start sampled in cycle 0: LOAD_W in cycles 1-4, STREAM 5-11, WAIT_RES 12-15, done = 1 in cycle 16, IDLE in cycle 17.
REQ-036 busy SHALL be high in cycles 1-16.

Reset
REQ-037 With rst = 1 at a clock edge: state SHALL become IDLE, all counters 0, and busy, done, mem_we, w_valid, a_valid and res_ready 0.
REQ-038 Under reset, mem_addr and w_row SHALL be 0 and mem_di SHALL be 0.
REQ-039 rst SHALL take priority over start.
REQ-040 Reset mid-job (any state) SHALL abort the job: no further reads, no writes and no done pulse; a partially written output region is left as is.

Verification
REQ-041 Nominal job on the default BRAM image: in cycle 2, w_valid = 1, w_row = 0 and w_data = 0x0001000000000005; in cycle 5, w_row = 3 and w_data = 0x0000000700010006; in cycle 6, a_data = 0x0000000000000009; in cycle 12, a_data = 0x0004000000000000.
REQ-042 Result writeback: res_data sequence 0x00170051002b0043, 0x002600ad00650055, 0x002b00e800720050, 0x002500dc005e0047 -> writes to addresses 11-14 in cycles 12-15, then done in cycle 16.
REQ-043 Stalled results: res_valid low for 5 cycles in WAIT_RES -> mem_we = 0 and res_ready = 1 throughout; done is delayed by exactly 5 cycles.
REQ-044 Spurious inputs: start pulsed in cycle 7 and res_valid high in cycles 1-11 -> no restart and no write before cycle 12.
REQ-045 Reset in cycle 8 (STREAM) -> cycle 9 is IDLE with all outputs 0, no done pulse, and a fresh start then runs the REQ-035 timeline.
REQ-046 Back-to-back: start high continuously -> second job LOAD_W begins in cycle 18 and done pulses in cycles 16 and 33.
